ascon_perm_ctrl: RTL and testbench
==================================

// Module: ascon_perm_ctrl
// PURPOSE
//  Sequences one ASCON permutation (p^a or p^b) over the shared round datapath.
//  Drives the state-select mux: input state on the first round, round-output feedback after.
//  Also drives the state-register enable and the round-constant index, and reports completion.
//  Sits between the ASCON mode FSM (start/mode requester) and the mux/round/state-register datapath.
// PARAMETERS
//  PA_ROUNDS  12  rounds for p^a (initialisation/finalisation); legal 1..12
//  PB_ROUNDS  6   rounds for p^b (data processing); legal 1..PA_ROUNDS
//  RND_W      4   width of round-constant index output
// PORTS
//  clock_i      in   1      system clock, all logic on rising edge
//  reset_i      in   1      synchronous, active-high reset
//  start_i      in   1      request one permutation; sampled only in IDLE or DONE
//  mode_i       in   1      0 = p^a (PA_ROUNDS), 1 = p^b (PB_ROUNDS); latched with start_i
//  data_sel_o   out  1      mux select: 0 = external state_i, 1 = feedback state_o_i
//  state_en_o   out  1      state-register load enable, high on every round cycle
//  round_o      out  RND_W  round-constant index i (12-N .. 11)
//  busy_o       out  1      high in FIRST and ROUND states
//  done_o       out  1      one-cycle pulse after the last round is loaded
//  (ASCON_PERM_ABORT_EN only) abort_i  in  1   cancel a running permutation
// BEHAVIOUR
//  - Clock clock_i; reset_i synchronous, active-high. In reset: state=IDLE, data_sel_o=0,
//    state_en_o=0, round_o=0, busy_o=0, done_o=0, latched round count N cleared.
//  - All outputs registered (Moore); no combinational path from inputs to outputs.
//  - FSM states: IDLE, FIRST, ROUND, DONE.
//    IDLE : start_i=1 -> FIRST; latch N = mode_i ? PB_ROUNDS : PA_ROUNDS.
//    FIRST: data_sel_o=0, state_en_o=1, round_o=12-N. N==1 -> DONE, else -> ROUND.
//    ROUND: data_sel_o=1, state_en_o=1, round_o increments by 1 per cycle.
//           round_o==11 -> DONE.
//    DONE : done_o=1, busy_o=0, state_en_o=0. start_i=1 -> FIRST (back-to-back), else -> IDLE.
//  - Latency: start_i sampled at edge t -> FIRST at t+1, last round at t+N, done_o at t+N+1.
//    Back-to-back throughput: one permutation every N+1 cycles.
//  - round_o arithmetic: unsigned RND_W bits, starts at 12-N, ends at 11, never wraps past 11.
//    Holds its last value in IDLE/DONE.
//  - data_sel_o holds its last value when state_en_o=0 (don't-care for the datapath).
//  - start_i in FIRST/ROUND ignored, no queueing. mode_i changes while busy have no effect.
//  - Reset mid-permutation: next cycle IDLE, all outputs at reset values; no done_o pulse.
//  - Illegal parameters (PA_ROUNDS>12, PB_ROUNDS>PA_ROUNDS, either 0) stop elaboration via
//    $error in a generate-time check.
// CONFIGURATION
//  ASCON_PERM_ABORT_EN defined:
//    - abort_i port exists.
//    - abort_i=1 in FIRST/ROUND -> IDLE next cycle, state_en_o=0, no done_o.
//    - abort_i has priority over the round transition; it is ignored in IDLE/DONE.
//    - abort_i and reset_i together: reset wins.
//  ASCON_PERM_ABORT_EN undefined:
//    - No abort_i port; a permutation always runs to completion unless reset.
// TESTING
//  1. Reset: reset_i=1 for 2 cycles -> all outputs 0, FSM in IDLE; start_i held 1 during reset is ignored.
//  2. p^a: start_i=1, mode_i=0 at t0 -> data_sel_o=0/round_o=0 at t1; data_sel_o=1/round_o=1..11
//     at t2..t12; state_en_o high t1..t12; done_o=1 only at t13.
//  3. p^b: mode_i=1 -> round_o 6..11 over t1..t6, done_o at t7; mode_i toggled to 0 at t3 has no effect.
//  4. Back-to-back: start_i=1 in DONE cycle -> FIRST next cycle, no IDLE gap; the second done_o
//     comes N+1 cycles after the first.
//  5. Busy ignore / reset mid-op: start_i pulsed at t5 of p^a -> no restart. reset_i at t7 ->
//     IDLE at t8, done_o never asserted.
//  6. (ASCON_PERM_ABORT_EN) abort_i=1 at t4 of p^a -> IDLE at t5, state_en_o=0, no done_o;
//     a fresh start_i at t6 runs a full 12 rounds.

Source files
------------

// File: rtl/ascon_perm_ctrl.sv
// ascon_perm_ctrl: round sequencer for one ASCON permutation (p^a / p^b).
// Optional abort_i port when ASCON_PERM_ABORT_EN is defined.
module ascon_perm_ctrl #(
    parameter int PA_ROUNDS = 12,
    parameter int PB_ROUNDS = 6,
    parameter int RND_W     = 4
) (
    input  logic             clock_i,
    input  logic             reset_i,
    input  logic             start_i,
    input  logic             mode_i,
    output logic             data_sel_o,
    output logic             state_en_o,
    output logic [RND_W-1:0] round_o,
    output logic             busy_o,
    output logic             done_o
`ifdef ASCON_PERM_ABORT_EN
    ,
    input  logic             abort_i
`endif
);

    typedef enum logic [1:0] {
        IDLE,
        FIRST,
        ROUND,
        DONE
    } state_t;

    localparam logic [RND_W-1:0] PA_START = RND_W'(12 - PA_ROUNDS);
    localparam logic [RND_W-1:0] PB_START = RND_W'(12 - PB_ROUNDS);
    localparam logic [RND_W-1:0] LAST_RND = RND_W'(11);
    localparam logic [3:0]       PA_N     = 4'(PA_ROUNDS);
    localparam logic [3:0]       PB_N     = 4'(PB_ROUNDS);

    if (PA_ROUNDS < 1 || PA_ROUNDS > 12 ||
        PB_ROUNDS < 1 || PB_ROUNDS > PA_ROUNDS) begin : g_bad_rounds
        $error("ascon_perm_ctrl: illegal PA_ROUNDS/PB_ROUNDS");
    end

    state_t     state_q;
    logic [3:0] n_q;

    logic abort;
`ifdef ASCON_PERM_ABORT_EN
    assign abort = abort_i;
`else
    assign abort = 1'b0;
`endif

    // Sequencer FSM with all outputs registered alongside the state.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q    <= IDLE;
            n_q        <= '0;
            data_sel_o <= 1'b0;
            state_en_o <= 1'b0;
            round_o    <= '0;
            busy_o     <= 1'b0;
            done_o     <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE, DONE: begin
                    done_o <= 1'b0;
                    if (start_i) begin
                        state_q    <= FIRST;
                        n_q        <= mode_i ? PB_N : PA_N;
                        round_o    <= mode_i ? PB_START : PA_START;
                        data_sel_o <= 1'b0;
                        state_en_o <= 1'b1;
                        busy_o     <= 1'b1;
                    end else begin
                        state_q    <= IDLE;
                        state_en_o <= 1'b0;
                        busy_o     <= 1'b0;
                    end
                end
                FIRST: begin
                    if (abort) begin
                        state_q    <= IDLE;
                        state_en_o <= 1'b0;
                        busy_o     <= 1'b0;
                    end else if (n_q == 4'd1) begin
                        state_q    <= DONE;
                        state_en_o <= 1'b0;
                        busy_o     <= 1'b0;
                        done_o     <= 1'b1;
                    end else begin
                        state_q    <= ROUND;
                        data_sel_o <= 1'b1;
                        round_o    <= round_o + 1'b1;
                    end
                end
                ROUND: begin
                    if (abort) begin
                        state_q    <= IDLE;
                        state_en_o <= 1'b0;
                        busy_o     <= 1'b0;
                    end else if (round_o == LAST_RND) begin
                        state_q    <= DONE;
                        state_en_o <= 1'b0;
                        busy_o     <= 1'b0;
                        done_o     <= 1'b1;
                    end else begin
                        round_o <= round_o + 1'b1;
                    end
                end
                default: begin
                    state_q    <= IDLE;
                    state_en_o <= 1'b0;
                    busy_o     <= 1'b0;
                    done_o     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ascon_perm_ctrl.sv
// tb_ascon_perm_ctrl: directed self-checking bench for ascon_perm_ctrl.
// Covers reset, p^a, p^b, back-to-back, busy-ignore, reset and abort.
module tb_ascon_perm_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       mode;
    logic       sel;
    logic       en;
    logic [3:0] rnd;
    logic       busy;
    logic       done;
`ifdef ASCON_PERM_ABORT_EN
    logic       abort;
`endif

    int errors = 0;
    int checks = 0;
    int done_cnt;

    always #5 clk = ~clk;

    ascon_perm_ctrl dut (
        .clock_i    (clk),
        .reset_i    (rst),
        .start_i    (start),
        .mode_i     (mode),
        .data_sel_o (sel),
        .state_en_o (en),
        .round_o    (rnd),
        .busy_o     (busy),
        .done_o     (done)
`ifdef ASCON_PERM_ABORT_EN
        ,
        .abort_i    (abort)
`endif
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic e_sel, input logic e_en,
                       input logic [3:0] e_rnd, input logic e_busy,
                       input logic e_done);
        logic [7:0] obs;
        logic [7:0] exp;
        obs = {sel, en, rnd, busy, done};
        exp = {e_sel, e_en, e_rnd, e_busy, e_done};
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b1;
        mode  = 1'b0;
`ifdef ASCON_PERM_ABORT_EN
        abort = 1'b0;
`endif
        // reset with start held high
        step();
        chk("rst1", 0, 0, 4'd0, 0, 0);
        step();
        chk("rst2", 0, 0, 4'd0, 0, 0);
        rst   = 1'b0;
        start = 1'b0;
        step();
        chk("idle", 0, 0, 4'd0, 0, 0);

        // p^a full run
        start = 1'b1;
        mode  = 1'b0;
        step();
        start = 1'b0;
        chk("pa_t1", 0, 1, 4'd0, 1, 0);
        for (int k = 2; k <= 12; k++) begin
            step();
            chk($sformatf("pa_t%0d", k), 1, 1, 4'(k - 1), 1, 0);
        end
        step();
        chk("pa_done", 1, 0, 4'd11, 0, 1);
        step();
        chk("pa_idle", 1, 0, 4'd11, 0, 0);

        // p^b with mode toggle while busy
        start = 1'b1;
        mode  = 1'b1;
        step();
        start = 1'b0;
        chk("pb_t1", 0, 1, 4'd6, 1, 0);
        step();
        chk("pb_t2", 1, 1, 4'd7, 1, 0);
        step();
        chk("pb_t3", 1, 1, 4'd8, 1, 0);
        mode = 1'b0;
        for (int k = 4; k <= 6; k++) begin
            step();
            chk($sformatf("pb_t%0d", k), 1, 1, 4'(k + 5), 1, 0);
        end
        step();
        chk("pb_done", 1, 0, 4'd11, 0, 1);
        step();
        chk("pb_idle", 1, 0, 4'd11, 0, 0);

        // back-to-back p^b
        start = 1'b1;
        mode  = 1'b1;
        step();
        start = 1'b0;
        chk("bb_a_t1", 0, 1, 4'd6, 1, 0);
        for (int k = 2; k <= 6; k++) step();
        chk("bb_a_t6", 1, 1, 4'd11, 1, 0);
        step();
        chk("bb_a_done", 1, 0, 4'd11, 0, 1);
        start = 1'b1;
        step();
        start = 1'b0;
        chk("bb_b_t1", 0, 1, 4'd6, 1, 0);
        done_cnt = 0;
        for (int k = 2; k <= 6; k++) begin
            step();
            if (done) done_cnt++;
        end
        chk_int("bb_b_nodone", done_cnt, 0);
        step();
        chk("bb_b_done", 1, 0, 4'd11, 0, 1);
        step();
        chk("bb_idle", 1, 0, 4'd11, 0, 0);

        // busy ignore then reset mid-op
        start = 1'b1;
        mode  = 1'b0;
        step();
        start = 1'b0;
        chk("bi_t1", 0, 1, 4'd0, 1, 0);
        for (int k = 2; k <= 5; k++) step();
        chk("bi_t5", 1, 1, 4'd4, 1, 0);
        start = 1'b1;
        mode  = 1'b1;
        step();
        start = 1'b0;
        chk("bi_t6", 1, 1, 4'd5, 1, 0);
        step();
        chk("bi_t7", 1, 1, 4'd6, 1, 0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("bi_rst", 0, 0, 4'd0, 0, 0);
        done_cnt = 0;
        for (int k = 0; k < 15; k++) begin
            step();
            if (done || busy) done_cnt++;
        end
        chk_int("bi_quiet", done_cnt, 0);

`ifdef ASCON_PERM_ABORT_EN
        // abort mid p^a then fresh full run
        start = 1'b1;
        mode  = 1'b0;
        step();
        start = 1'b0;
        for (int k = 2; k <= 4; k++) step();
        chk("ab_t4", 1, 1, 4'd3, 1, 0);
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("ab_t5", 1, 0, 4'd3, 0, 0);
        start = 1'b1;
        step();
        start = 1'b0;
        chk("ab2_t1", 0, 1, 4'd0, 1, 0);
        done_cnt = 0;
        for (int k = 2; k <= 12; k++) begin
            step();
            if (done || !en) done_cnt++;
        end
        chk_int("ab2_run", done_cnt, 0);
        step();
        chk("ab2_done", 1, 0, 4'd11, 0, 1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
